// File: rtl/fx_pkg.sv
// Shared fixed-point defaults and FSM state type for the multiplier/accumulator stages.
package fx_pkg;

    localparam int FX_WIDTH = 32;
    localparam int FX_QINT  = 16;
    localparam int FX_QFRAC = FX_WIDTH - FX_QINT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } fx_state_e;

endpackage

// File: rtl/fx_sat.sv
// Narrows a wide signed value to OUT_W bits; with SAT_EN it clamps to the signed
// limits and flags the clamp, otherwise it keeps the low OUT_W bits.
module fx_sat #(
    parameter int IN_W   = 40,
    parameter int OUT_W  = 32,
    parameter bit SAT_EN = 1'b1
) (
    input  logic signed [IN_W-1:0]  i_data,
    output logic signed [OUT_W-1:0] o_data,
    output logic                    o_clamped
);

    logic w_fits;

    // The value fits when every bit above the output sign bit matches the input sign.
    assign w_fits    = (i_data[IN_W-1:OUT_W-1] == {(IN_W-OUT_W+1){i_data[IN_W-1]}});
    assign o_clamped = SAT_EN && !w_fits;

    always_comb begin
        o_data = i_data[OUT_W-1:0];
        if (o_clamped) begin
            o_data = i_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                    : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fx_accum.sv
// Counted Q-format accumulator: sums 'count' qualified samples and emits one result.
// Define FX_ACCUM_SAT_EN for saturating adds/narrowing; default build wraps and truncates.
module fx_accum
    import fx_pkg::*;
#(
    parameter int WIDTH = FX_WIDTH,
    parameter int QINT  = FX_QINT,
    parameter int QFRAC = WIDTH - QINT,
    parameter int GUARD = 8,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [CNT_W-1:0]        count,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] din,
    output logic                    busy,
    output logic signed [WIDTH-1:0] sum,
    output logic                    valid_out,
    output logic                    sat
);

    localparam int ACC_W = WIDTH + GUARD;

`ifdef FX_ACCUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    // The binary point never moves, so the Q split only has to be self-consistent.
    if (QINT + QFRAC != WIDTH) begin : g_qFormatCheck
        $error("fx_accum: QINT + QFRAC must equal WIDTH");
    end

    fx_state_e          r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_remaining;
    logic               r_sticky;
    logic [WIDTH-1:0]   r_sum;
    logic               r_validOut;
    logic               r_sat;
    logic               r_busy;

    logic [ACC_W-1:0]   w_addend;
    logic [ACC_W:0]     w_wide;
    logic               w_addOvf;
    logic [ACC_W-1:0]   w_accNext;
    logic [WIDTH-1:0]   w_narrow;
    logic               w_clamped;

    assign w_addend = {{GUARD{din[WIDTH-1]}}, din};
    assign w_wide   = {r_acc[ACC_W-1], r_acc} + {w_addend[ACC_W-1], w_addend};
    assign w_addOvf = SAT_EN && (w_wide[ACC_W] != w_wide[ACC_W-1]);

    always_comb begin
        w_accNext = w_wide[ACC_W-1:0];
        if (w_addOvf) begin
            w_accNext = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    fx_sat #(
        .IN_W   (ACC_W),
        .OUT_W  (WIDTH),
        .SAT_EN (SAT_EN)
    ) u_sat (
        .i_data    (r_acc),
        .o_data    (w_narrow),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_remaining <= '0;
            r_sticky    <= 1'b0;
            r_sum       <= '0;
            r_validOut  <= 1'b0;
            r_sat       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_validOut <= 1'b0;
            r_sat      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= '0;
                        r_sticky <= 1'b0;
                        r_busy   <= 1'b1;
                        if (count != '0) begin
                            r_remaining <= count;
                            r_state     <= ACCUM;
                        end else begin
                            r_state     <= DONE;
                        end
                    end
                end
                ACCUM: begin
                    if (valid_in) begin
                        r_acc       <= w_accNext;
                        r_sticky    <= r_sticky | w_addOvf;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_sum      <= w_narrow;
                    r_validOut <= 1'b1;
                    r_sat      <= r_sticky | w_clamped;
                    r_busy     <= 1'b0;
                    r_state    <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign sum       = r_sum;
    assign valid_out = r_validOut;
    assign sat       = r_sat;

endmodule

// File: tb/tb_fx_accum.sv
// Self-checking bench for fx_accum: spec vectors, corner sequences and random runs
// against an arithmetic reference model (honours FX_ACCUM_SAT_EN if defined).
module tb_fx_accum;

`ifdef FX_ACCUM_SAT_EN
    localparam longint ACC_MAX = 64'sd549755813887;
    localparam longint ACC_MIN = -64'sd549755813888;
    localparam longint Q_MAX   = 64'sd2147483647;
    localparam longint Q_MIN   = -64'sd2147483648;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [15:0]        count;
    logic               valid_in;
    logic signed [31:0] din;
    logic               busy;
    logic signed [31:0] sum;
    logic               valid_out;
    logic               sat;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        string            name;
        int               n;
        logic [3:0][31:0] s;
        logic [3:0][7:0]  g;
        bit               junk;
        logic [31:0]      expSum;
        logic             expSat;
    } vec_t;

    vec_t        vecs[5];
    logic [31:0] sq[$];
    int          gq[$];

    always #5 clk = ~clk;

    fx_accum #(
        .WIDTH (32),
        .QINT  (16),
        .GUARD (8),
        .CNT_W (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .valid_in  (valid_in),
        .din       (din),
        .busy      (busy),
        .sum       (sum),
        .valid_out (valid_out),
        .sat       (sat)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic checkFlag(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    // Reference: true signed sum, optionally clamped per add and at the final narrowing.
    function automatic void modelAccum(input logic [31:0] samples[$], output logic [31:0] expSum,
                                       output logic expSat);
        longint acc  = 0;
        logic   flag = 1'b0;
        foreach (samples[i]) begin
            acc += longint'($signed(samples[i]));
`ifdef FX_ACCUM_SAT_EN
            if (acc > ACC_MAX) begin acc = ACC_MAX; flag = 1'b1; end
            else if (acc < ACC_MIN) begin acc = ACC_MIN; flag = 1'b1; end
`endif
        end
`ifdef FX_ACCUM_SAT_EN
        if (acc > Q_MAX) begin expSum = 32'h7FFF_FFFF; flag = 1'b1; end
        else if (acc < Q_MIN) begin expSum = 32'h8000_0000; flag = 1'b1; end
        else expSum = acc[31:0];
`else
        expSum = acc[31:0];
`endif
        expSat = flag;
    endfunction

    // Called #1 after a rising edge with the DUT idle; runs one full accumulation.
    task automatic applyStimulus(input string name, input logic [31:0] samples[$], input int gaps[$],
                                 input bit junk, input logic [31:0] expSum, input logic expSat);
        start = 1'b1;
        count = 16'(samples.size());
        if (junk) begin
            valid_in = 1'b1;
            din      = 32'h1234_5678;
        end
        @(posedge clk); #1;
        start    = 1'b0;
        valid_in = 1'b0;
        checkFlag({name, " busyAfterStart"}, busy, 1'b1);
        foreach (samples[i]) begin
            repeat (gaps[i]) begin
                din = $urandom;
                @(posedge clk); #1;
            end
            valid_in = 1'b1;
            din      = samples[i];
            @(posedge clk); #1;
            valid_in = 1'b0;
            din      = $urandom;
        end
        checkFlag({name, " validOutEarly"}, valid_out, 1'b0);
        checkFlag({name, " busyInDone"}, busy, 1'b1);
        @(posedge clk); #1;
        checkFlag({name, " validOut"}, valid_out, 1'b1);
        checkOutput({name, " sum"}, sum, expSum);
        checkFlag({name, " sat"}, sat, expSat);
        checkFlag({name, " busyIdle"}, busy, 1'b0);
        @(posedge clk); #1;
        checkFlag({name, " validOutPulse"}, valid_out, 1'b0);
        checkFlag({name, " satPulse"}, sat, 1'b0);
        checkOutput({name, " sumHeld"}, sum, expSum);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] eSum;
        logic        eSat;

        vecs[0] = '{name: "mixedQ", n: 4,
                    s: {32'h0000_4000, 32'hFFFF_8000, 32'h0002_0000, 32'h0001_0000},
                    g: {8'd0, 8'd0, 8'd0, 8'd0}, junk: 1'b1, expSum: 32'h0002_C000, expSat: 1'b0};
        vecs[1] = '{name: "gapped", n: 3,
                    s: {32'h0, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
                    g: {8'd0, 8'd5, 8'd2, 8'd0}, junk: 1'b0, expSum: 32'h0003_0000, expSat: 1'b0};
`ifdef FX_ACCUM_SAT_EN
        vecs[2] = '{name: "posOverflow", n: 2, s: {32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                    g: '0, junk: 1'b0, expSum: 32'h7FFF_FFFF, expSat: 1'b1};
        vecs[4] = '{name: "negOverflow", n: 2, s: {32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000},
                    g: '0, junk: 1'b0, expSum: 32'h8000_0000, expSat: 1'b1};
`else
        vecs[2] = '{name: "posOverflow", n: 2, s: {32'h0, 32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
                    g: '0, junk: 1'b0, expSum: 32'hFFFF_FFFE, expSat: 1'b0};
        vecs[4] = '{name: "negOverflow", n: 2, s: {32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000},
                    g: '0, junk: 1'b0, expSum: 32'h0000_0000, expSat: 1'b0};
`endif
        vecs[3] = '{name: "zeroCount", n: 0, s: '0, g: '0, junk: 1'b0, expSum: 32'h0, expSat: 1'b0};

        rst_n    = 1'b0;
        start    = 1'b0;
        count    = '0;
        valid_in = 1'b0;
        din      = '0;
        repeat (3) @(posedge clk);
        #1;
        checkFlag("reset busy", busy, 1'b0);
        checkFlag("reset validOut", valid_out, 1'b0);
        checkFlag("reset sat", sat, 1'b0);
        checkOutput("reset sum", sum, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            sq.delete();
            gq.delete();
            for (int k = 0; k < vecs[i].n; k++) begin
                sq.push_back(vecs[i].s[k]);
                gq.push_back(int'(vecs[i].g[k]));
            end
            applyStimulus(vecs[i].name, sq, gq, vecs[i].junk, vecs[i].expSum, vecs[i].expSat);
        end

        // A start arriving mid-run or during DONE must not disturb the active count.
        start = 1'b1; count = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        valid_in = 1'b1; din = 32'h0001_0000;
        @(posedge clk); #1;
        valid_in = 1'b0; start = 1'b1; count = 16'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            valid_in = 1'b1;
            din      = k << 16;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        checkFlag("startIgnored validOutEarly", valid_out, 1'b0);
        start = 1'b1; count = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        checkFlag("startIgnored validOut", valid_out, 1'b1);
        checkOutput("startIgnored sum", sum, 32'h000A_0000);
        checkFlag("startIgnoredInDone busy", busy, 1'b0);
        @(posedge clk); #1;
        checkFlag("startIgnoredInDone stillIdle", busy, 1'b0);

        // Reset in the middle of a run drops it without a result.
        start = 1'b1; count = 16'd4;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) begin
            valid_in = 1'b1; din = 32'h0001_0000;
            @(posedge clk); #1;
        end
        valid_in = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkFlag("midReset busy", busy, 1'b0);
        checkFlag("midReset validOut", valid_out, 1'b0);
        checkFlag("midReset sat", sat, 1'b0);
        checkOutput("midReset sum", sum, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            checkFlag("postReset noValidOut", valid_out, 1'b0);
            checkFlag("postReset idle", busy, 1'b0);
        end
        sq = '{32'h0000_8000};
        gq = '{0};
        applyStimulus("resetRecovery", sq, gq, 1'b0, 32'h0000_8000, 1'b0);

        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 6);
            sq.delete();
            gq.delete();
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 3) == 0) sq.push_back($urandom);
                else sq.push_back(32'($signed($urandom_range(0, 2097152)) - 1048576));
                gq.push_back($urandom_range(0, 3));
            end
            repeat ($urandom_range(0, 2)) begin
                valid_in = 1'b1;
                din      = $urandom;
                @(posedge clk); #1;
                checkFlag("idleSample busy", busy, 1'b0);
            end
            valid_in = 1'b0;
            modelAccum(sq, eSum, eSat);
            applyStimulus($sformatf("random%0d", r), sq, gq, bit'($urandom_range(0, 1)), eSum, eSat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
